// File: rtl/capiano_pkg.sv
// Frame geometry, frame-buffer address layout and RGB333 field offsets,
// shared by the camera buffer writer and the key scanner.
package capiano_pkg;

  localparam int FRAME_W = 160;
  localparam int FRAME_H = 120;

  localparam int ADDR_W = 32;
  localparam int X_LSB  = 2;
  localparam int X_W    = 8;
  localparam int Y_LSB  = 18;
  localparam int Y_W    = 7;

  localparam int PIX_W  = 9;
  localparam int CH_W   = 3;
  localparam int R_LSB  = 6;
  localparam int G_LSB  = 3;
  localparam int B_LSB  = 0;

  localparam int LUMA_W = 5;
  localparam int CNT_W  = 12;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } scan_state_t;

  // Byte address of pixel (x, y); unused address bits stay zero.
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [X_W-1:0] x,
                                                input logic [Y_W-1:0] y);
    logic [ADDR_W-1:0] a;
    a = '0;
    a[Y_LSB +: Y_W] = y;
    a[X_LSB +: X_W] = x;
    return a;
  endfunction

endpackage

// File: rtl/key_scanner_luma_cmp.sv
// RGB333 pixel -> dark flag (R+G+B < LUMA_TH); purely combinational.
// Latency 0; backpressure: none.
module luma_cmp
  import capiano_pkg::*;
#(
  parameter int LUMA_TH = 6
) (
  input  logic [PIX_W-1:0] pix,
  output logic             dark
);

  logic [LUMA_W-1:0] luma;

  always_comb begin
    luma = LUMA_W'(pix[R_LSB +: CH_W]) + LUMA_W'(pix[G_LSB +: CH_W])
         + LUMA_W'(pix[B_LSB +: CH_W]);
    dark = 32'(luma) < 32'(LUMA_TH);
  end

endmodule

// File: rtl/key_scanner.sv
// Scans rows ROW_START..ROW_END of the frame buffer, counts dark pixels per key band
// and publishes key_mask; done 1 frame-slice + 2 cycles after start; no backpressure, start ignored while busy.
module key_scanner
  import capiano_pkg::*;
#(
  parameter int NUM_KEYS  = 8,
  parameter int KEY_W     = 20,
  parameter int ROW_START = 80,
  parameter int ROW_END   = 119,
  parameter int LUMA_TH   = 6,
  parameter int CNT_TH    = 200
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic [ADDR_W-1:0]   addr,
  input  logic [PIX_W-1:0]    q,
  output logic                busy,
  output logic                done,
  output logic [NUM_KEYS-1:0] key_mask
);

  localparam int KEY_IW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int SUB_W  = (KEY_W > 1) ? $clog2(KEY_W) : 1;

  scan_state_t       state_q, state_d;
  logic              accept;
  logic [X_W-1:0]    x_q;
  logic [Y_W-1:0]    y_q;
  logic [SUB_W-1:0]  sub_q;
  logic [KEY_IW-1:0] key_q;
  logic              row_end;
  logic              last_pix;

  logic              pix_vld_q;
  logic [KEY_IW-1:0] pix_key_q;
  logic              dark;
  logic [CNT_W-1:0]  cnt_q [NUM_KEYS];
  logic              done_q;

  assign row_end  = (x_q == X_W'(FRAME_W - 1));
  assign last_pix = row_end && (y_q == Y_W'(ROW_END));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          accept  = 1'b1;
          state_d = S_SCAN;
        end
      end
      S_SCAN:  if (last_pix) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Raster position; band is tracked by sub/key counters so no divide is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      sub_q <= '0;
      key_q <= '0;
    end else if (accept) begin
      x_q   <= '0;
      y_q   <= Y_W'(ROW_START);
      sub_q <= '0;
      key_q <= '0;
    end else if (state_q == S_SCAN && !last_pix) begin
      if (row_end) begin
        x_q   <= '0;
        y_q   <= y_q + Y_W'(1);
        sub_q <= '0;
        key_q <= '0;
      end else begin
        x_q <= x_q + X_W'(1);
        if (sub_q == SUB_W'(KEY_W - 1)) begin
          sub_q <= '0;
          key_q <= key_q + KEY_IW'(1);
        end else begin
          sub_q <= sub_q + SUB_W'(1);
        end
      end
    end
  end

  // Address is a pure function of the raster registers, so it holds in IDLE.
  assign addr = fb_addr(x_q, y_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_vld_q <= 1'b0;
      pix_key_q <= '0;
    end else begin
      pix_vld_q <= (state_q == S_SCAN);
      pix_key_q <= key_q;
    end
  end

  luma_cmp #(
    .LUMA_TH(LUMA_TH)
  ) u_luma_cmp (
    .pix  (q),
    .dark (dark)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_KEYS; k++) cnt_q[k] <= '0;
    end else if (accept) begin
      for (int k = 0; k < NUM_KEYS; k++) cnt_q[k] <= '0;
    end else if (pix_vld_q && dark) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (pix_key_q == KEY_IW'(k) && cnt_q[k] != '1) begin
          cnt_q[k] <= cnt_q[k] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_mask <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state_q == S_DONE);
      if (state_q == S_DONE) begin
        for (int k = 0; k < NUM_KEYS; k++) begin
          key_mask[k] <= 32'(cnt_q[k]) >= 32'(CNT_TH);
        end
      end
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_key_scanner.sv
// Directed bench for key_scanner: pattern table plus restart/reset corner cases.
module tb_key_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] addr1, addr2;
  logic [8:0]  q1, q2;
  logic        busy1, busy2, done1, done2;
  logic [7:0]  mask1, mask2;
  int          mode;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  key_scanner u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr(addr1), .q(q1),
    .busy(busy1), .done(done1), .key_mask(mask1)
  );

  key_scanner #(.CNT_TH(401)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .addr(addr2), .q(q2),
    .busy(busy2), .done(done2), .key_mask(mask2)
  );

  function automatic logic [8:0] pix(input logic [31:0] a, input int m);
    logic [7:0] x;
    logic [6:0] y;
    x = a[9:2];
    y = a[24:18];
    case (m)
      0: return 9'h1FF;
      1: return 9'h000;
      2: return (x >= 40 && x <= 59) ? 9'h000 : 9'h1FF;
      3: return (x >= 40 && x <= 49) ? 9'h000 : 9'h1FF;
      4: return (y < 90) ? 9'h000 : 9'h1FF;
      5: return 9'h091;                       // 2+2+1 = 5
      6: return 9'h092;                       // 2+2+2 = 6
      7: return (x < 20) ? 9'h091 : (x < 40) ? 9'h092 : 9'h1FF;
      8: return (y >= 110) ? 9'h000 : 9'h1FF;
      default: return 9'h1FF;
    endcase
  endfunction

  // Frame buffer with one cycle of read latency.
  always @(posedge clk) begin
    q1 <= pix(addr1, mode);
    q2 <= pix(addr2, mode);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Pulses start, then watches done/addr; extra start pulses at cycles ra and rb.
  task automatic run_scan(input int ra, input int rb,
                          output int lat1, output int lat2, output int nd1, output int nd2,
                          output int bad, output logic [31:0] a_first, output logic [31:0] a_last,
                          output logic busy0, output logic busy_end);
    logic [31:0] e;
    lat1 = -1; lat2 = -1; nd1 = 0; nd2 = 0; bad = 0;
    a_first = '0; a_last = '0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    busy0 = busy1;
    for (int c = 0; c < 6600; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      start = (c == ra || c == rb);
      if (c < 6400) begin
        e = '0;
        e[24:18] = 7'(80 + c / 160);
        e[9:2]   = 8'(c % 160);
        if (addr1 !== e) bad++;
        if (c == 0) a_first = addr1;
        if (c == 6399) a_last = addr1;
      end
      if (done1 === 1'b1) begin
        nd1++;
        if (lat1 < 0) lat1 = c;
      end
      if (done2 === 1'b1) begin
        nd2++;
        if (lat2 < 0) lat2 = c;
      end
      if (lat1 >= 0 && c >= lat1 + 20) break;
    end
    start = 1'b0;
    busy_end = busy1;
  endtask

  typedef struct {
    int         mode;
    logic [7:0] exp1;   // CNT_TH = 200
    logic [7:0] exp2;   // CNT_TH = 401
  } vec_t;

  vec_t vecs [9];

  initial begin
    int lat1, lat2, nd1, nd2, bad, nd;
    logic [31:0] af, al;
    logic b0, be;

    vecs[0] = '{0, 8'h00, 8'h00};
    vecs[1] = '{1, 8'hFF, 8'hFF};
    vecs[2] = '{2, 8'h04, 8'h04};
    vecs[3] = '{3, 8'h04, 8'h00};
    vecs[4] = '{4, 8'hFF, 8'h00};
    vecs[5] = '{5, 8'hFF, 8'hFF};
    vecs[6] = '{6, 8'h00, 8'h00};
    vecs[7] = '{7, 8'h01, 8'h01};
    vecs[8] = '{8, 8'hFF, 8'h00};

    rst_n = 1'b0;
    start = 1'b0;
    mode  = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_mask", 32'(mask1), 32'd0);
    check("rst_addr", addr1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      mode = vecs[i].mode;
      run_scan(-1, -1, lat1, lat2, nd1, nd2, bad, af, al, b0, be);
      check($sformatf("vec%0d_latency", i), 32'(lat1), 32'd6402);
      check($sformatf("vec%0d_latency2", i), 32'(lat2), 32'd6402);
      check($sformatf("vec%0d_mask", i), 32'(mask1), 32'(vecs[i].exp1));
      check($sformatf("vec%0d_mask_th401", i), 32'(mask2), 32'(vecs[i].exp2));
      if (i == 0) begin
        check("addr_first", af, 32'h0140_0000);
        check("addr_last", al, 32'h01DC_027C);
        check("addr_seq_errors", 32'(bad), 32'd0);
        check("busy_in_scan", 32'(b0), 32'd1);
        check("busy_after_done", 32'(be), 32'd0);
        check("done_pulses", 32'(nd1), 32'd1);
      end
    end

    // start during SCAN and during DONE must both be ignored
    mode = 1;
    run_scan(100, 6401, lat1, lat2, nd1, nd2, bad, af, al, b0, be);
    check("restart_done_pulses", 32'(nd1), 32'd1);
    check("restart_latency", 32'(lat1), 32'd6402);
    check("restart_busy_end", 32'(be), 32'd0);
    check("restart_mask", 32'(mask1), 32'hFF);

    // reset in the middle of a scan
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3000) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy1), 32'd0);
    check("abort_done", 32'(done1), 32'd0);
    check("abort_mask", 32'(mask1), 32'd0);
    check("abort_mask_th401", 32'(mask2), 32'd0);
    check("abort_addr", addr1, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (3500) begin
      @(posedge clk);
      #1;
      if (done1 === 1'b1) nd++;
    end
    check("abort_no_done", 32'(nd), 32'd0);
    check("abort_idle_busy", 32'(busy1), 32'd0);

    run_scan(-1, -1, lat1, lat2, nd1, nd2, bad, af, al, b0, be);
    check("post_reset_latency", 32'(lat1), 32'd6402);
    check("post_reset_mask", 32'(mask1), 32'hFF);
    check("post_reset_addr_errors", 32'(bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
